// File: rtl/tour_cmd_seq_if.sv
// Command-channel bundle between tour_cmd_seq, the UART wrapper and cmd_proc.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface tour_cmd_seq_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd_seq.sv
// Plays a Knight's Tour into cmd_proc as vertical/horizontal command pairs, else passes UART commands through.
// Optional macro TOUR_ABORT_EN: a UART command with opcode 4'hF aborts playback.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    output logic             tour_busy,
    output logic             tour_done,
    tour_cmd_seq_if.master   bus
);

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [7:0] RESP_IDLE = 8'hA5;
    localparam logic [7:0] RESP_TOUR = 8'h5A;

    state_t           state, nxt_state;
    logic [IDX_W-1:0] nxt_indx;
    logic             nxt_busy;
    logic             nxt_done;
    logic [7:0]       resp_q, nxt_resp;

    logic [2:0]       sel;
    logic [7:0]       v_head, h_head;
    logic [3:0]       v_sq, h_sq;
    logic [15:0]      vert_cmd, horz_cmd;

    // Lowest set bit selects the move; an all-zero move falls back to bit 0.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) sel = 3'(i);
        end
        v_head = 8'h00;
        v_sq   = 4'd2;
        h_head = 8'hBF;
        h_sq   = 4'd1;
        case (sel)
            3'd0: begin v_head = 8'h00; v_sq = 4'd2; h_head = 8'hBF; h_sq = 4'd1; end
            3'd1: begin v_head = 8'h00; v_sq = 4'd2; h_head = 8'h3F; h_sq = 4'd1; end
            3'd2: begin v_head = 8'h00; v_sq = 4'd1; h_head = 8'h3F; h_sq = 4'd2; end
            3'd3: begin v_head = 8'h7F; v_sq = 4'd1; h_head = 8'h3F; h_sq = 4'd2; end
            3'd4: begin v_head = 8'h7F; v_sq = 4'd2; h_head = 8'h3F; h_sq = 4'd1; end
            3'd5: begin v_head = 8'h7F; v_sq = 4'd2; h_head = 8'hBF; h_sq = 4'd1; end
            3'd6: begin v_head = 8'h7F; v_sq = 4'd1; h_head = 8'hBF; h_sq = 4'd2; end
            default: begin v_head = 8'h00; v_sq = 4'd1; h_head = 8'hBF; h_sq = 4'd2; end
        endcase
        vert_cmd = {4'b0010, v_head, v_sq};
        horz_cmd = {4'b0011, h_head, h_sq};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mv_indx   <= '0;
            tour_busy <= 1'b0;
            tour_done <= 1'b0;
            resp_q    <= RESP_IDLE;
        end else begin
            state     <= nxt_state;
            mv_indx   <= nxt_indx;
            tour_busy <= nxt_busy;
            tour_done <= nxt_done;
            resp_q    <= nxt_resp;
        end
    end

    assign bus.resp = resp_q;

    // Playback holds cmd on the current move's command through the wait state so it never glitches.
    always_comb begin
        nxt_state            = state;
        nxt_indx             = mv_indx;
        nxt_busy             = tour_busy;
        nxt_done             = 1'b0;
        nxt_resp             = resp_q;
        bus.cmd              = vert_cmd;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;

        case (state)
            IDLE: begin
                bus.cmd              = bus.cmd_UART;
                bus.cmd_rdy          = bus.cmd_rdy_UART;
                bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
                nxt_resp             = RESP_IDLE;
                if (start_tour) begin
                    nxt_state = VERT;
                    nxt_indx  = '0;
                    nxt_busy  = 1'b1;
                end
            end
            VERT: begin
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) nxt_state = WAIT_V;
            end
            WAIT_V: begin
                if (bus.send_resp) begin
                    nxt_state = HORZ;
                    nxt_resp  = RESP_TOUR;
                end
            end
            HORZ: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) nxt_state = WAIT_H;
            end
            WAIT_H: begin
                bus.cmd = horz_cmd;
                if (bus.send_resp) begin
                    if (mv_indx == IDX_W'(NUM_MOVES - 1)) begin
                        nxt_state = IDLE;
                        nxt_busy  = 1'b0;
                        nxt_done  = 1'b1;
                        nxt_resp  = RESP_IDLE;
                    end else begin
                        nxt_state = VERT;
                        nxt_indx  = mv_indx + IDX_W'(1);
                        nxt_resp  = RESP_TOUR;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

`ifdef TOUR_ABORT_EN
        // Abort wins over any playback transition in the same cycle.
        if (state != IDLE && bus.cmd_rdy_UART && bus.cmd_UART[15:12] == 4'hF) begin
            nxt_state            = IDLE;
            nxt_indx             = '0;
            nxt_busy             = 1'b0;
            nxt_done             = 1'b0;
            nxt_resp             = RESP_IDLE;
            bus.clr_cmd_rdy_UART = 1'b1;
        end
`else
        // Without abort support UART commands simply stay pending until playback ends.
`endif
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: expected commands/responses are queued per move and
// popped as the DUT presents them to a scripted cmd_proc.
module tb_tour_cmd_seq;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    logic             clk;
    logic             rst_n;
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic             tour_busy;
    logic             tour_done;

    tour_cmd_seq_if bus ();

    tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .tour_busy  (tour_busy),
        .tour_done  (tour_done),
        .bus        (bus.master)
    );

    logic [7:0]  moveTab [0:31];
    logic [15:0] cmdQ [$];
    logic [7:0]  respQ [$];
    int          checks;
    int          errors;
    int          doneCount;

    // Stand-in for TourLogic: the move at the requested index.
    assign move = moveTab[mv_indx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tour_done === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] expCmd(input logic [7:0] m, input bit horz);
        int b;
        int dy;
        int dx;
        b = 0;
        for (int i = 7; i >= 0; i--) if (m[i]) b = i;
        dy = 2; dx = 1;
        case (b)
            0: begin dy =  2; dx =  1; end
            1: begin dy =  2; dx = -1; end
            2: begin dy =  1; dx = -2; end
            3: begin dy = -1; dx = -2; end
            4: begin dy = -2; dx = -1; end
            5: begin dy = -2; dx =  1; end
            6: begin dy = -1; dx =  2; end
            default: begin dy = 1; dx = 2; end
        endcase
        if (!horz) return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
        return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] uartCmd, input logic uartRdy, input logic start);
        bus.cmd_UART     = uartCmd;
        bus.cmd_rdy_UART = uartRdy;
        start_tour       = start;
        tick();
        start_tour       = 1'b0;
    endtask

    task automatic pushMove(input int k, input bit last);
        cmdQ.push_back(expCmd(moveTab[k], 1'b0));
        respQ.push_back(8'h5A);
        cmdQ.push_back(expCmd(moveTab[k], 1'b1));
        respQ.push_back(last ? 8'hA5 : 8'h5A);
    endtask

    // Scripted cmd_proc: accept one command, then acknowledge it unless told to stop short.
    task automatic serviceCmd(input bit skipResp);
        int n;
        logic [15:0] exp;
        n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.cmd_rdy !== 1'b1) begin
            checkOutput("cmd_rdy_timeout", 32'(bus.cmd_rdy), 32'd1);
            return;
        end
        exp = cmdQ.pop_front();
        checkOutput("cmd", 32'(bus.cmd), 32'(exp));
        bus.clr_cmd_rdy = 1'b1;
        #1;
        checkOutput("clr_uart_blocked", 32'(bus.clr_cmd_rdy_UART), 32'd0);
        tick();
        bus.clr_cmd_rdy = 1'b0;
        checkOutput("cmd_rdy_low", 32'(bus.cmd_rdy), 32'd0);
        if (skipResp) return;
        tick();
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        checkOutput("resp", 32'(bus.resp), 32'(respQ.pop_front()));
    endtask

    task automatic playMove(input int k, input bit last);
        pushMove(k, last);
        checkOutput("mv_indx", 32'(mv_indx), 32'(k));
        serviceCmd(1'b0);
        serviceCmd(1'b0);
    endtask

    initial begin
        logic [7:0] tabInit [0:23];
        checks = 0; errors = 0; doneCount = 0;
        tabInit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                    8'h00, 8'h0C, 8'hF0, 8'h81, 8'h06, 8'h18, 8'h60, 8'hC0,
                    8'h03, 8'h30, 8'h22, 8'h44, 8'h88, 8'h11, 8'hFF, 8'h48};
        for (int i = 0; i < 32; i++) moveTab[i] = (i < 24) ? tabInit[i] : 8'h00;

        rst_n = 1'b0; start_tour = 1'b0;
        bus.cmd_UART = 16'h0000; bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        #12;
        checkOutput("rst_mv_indx", 32'(mv_indx), 32'd0);
        checkOutput("rst_busy", 32'(tour_busy), 32'd0);
        checkOutput("rst_done", 32'(tour_done), 32'd0);
        checkOutput("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        checkOutput("rst_resp", 32'(bus.resp), 32'hA5);
        rst_n = 1'b1;
        tick();

        // Idle passthrough
        bus.cmd_UART = 16'h2002; bus.cmd_rdy_UART = 1'b1;
        #1;
        checkOutput("pass_cmd", 32'(bus.cmd), 32'h2002);
        checkOutput("pass_rdy", 32'(bus.cmd_rdy), 32'd1);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        checkOutput("pass_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        checkOutput("pass_resp", 32'(bus.resp), 32'hA5);
        tick();
        bus.clr_cmd_rdy = 1'b0;

        // Full tour, started together with a pending UART command
        applyStimulus(16'h1234, 1'b1, 1'b1);
        checkOutput("start_busy", 32'(tour_busy), 32'd1);
        checkOutput("start_uart_kept", 32'(bus.clr_cmd_rdy_UART), 32'd0);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        checkOutput("spurious_rdy", 32'(bus.cmd_rdy), 32'd1);
        checkOutput("spurious_resp", 32'(bus.resp), 32'hA5);
        for (int k = 0; k < NUM_MOVES; k++) begin
            if (k == 5) applyStimulus(16'h1234, 1'b1, 1'b1);
            playMove(k, k == NUM_MOVES - 1);
        end
        checkOutput("end_done", 32'(tour_done), 32'd1);
        checkOutput("end_busy", 32'(tour_busy), 32'd0);
        checkOutput("end_queue", 32'(cmdQ.size()), 32'd0);
        tick();
        checkOutput("done_count", 32'(doneCount), 32'd1);
        checkOutput("done_pulse_low", 32'(tour_done), 32'd0);
        checkOutput("after_pass_cmd", 32'(bus.cmd), 32'h1234);
        checkOutput("after_pass_rdy", 32'(bus.cmd_rdy), 32'd1);

        // Reset in WAIT_H of move 7
        applyStimulus(16'h1234, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) playMove(k, 1'b0);
        pushMove(7, 1'b0);
        checkOutput("mv_indx", 32'(mv_indx), 32'd7);
        serviceCmd(1'b0);
        serviceCmd(1'b1);
        respQ.delete();
        checkOutput("waith_rdy", 32'(bus.cmd_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_idx", 32'(mv_indx), 32'd0);
        checkOutput("midrst_busy", 32'(tour_busy), 32'd0);
        checkOutput("midrst_rdy", 32'(bus.cmd_rdy), 32'd1);
        checkOutput("midrst_resp", 32'(bus.resp), 32'hA5);
        #4;
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("midrst_no_done", 32'(doneCount), 32'd1);

`ifdef TOUR_ABORT_EN
        applyStimulus(16'h1234, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) playMove(k, 1'b0);
        pushMove(3, 1'b0);
        serviceCmd(1'b1);
        cmdQ.delete();
        respQ.delete();
        bus.cmd_UART = 16'hF000; bus.cmd_rdy_UART = 1'b1;
        #1;
        checkOutput("abort_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        tick();
        bus.cmd_rdy_UART = 1'b0;
        checkOutput("abort_busy", 32'(tour_busy), 32'd0);
        checkOutput("abort_idx", 32'(mv_indx), 32'd0);
        checkOutput("abort_resp", 32'(bus.resp), 32'hA5);
        checkOutput("abort_clr_low", 32'(bus.clr_cmd_rdy_UART), 32'd0);
        tick();
        checkOutput("abort_no_done", 32'(doneCount), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
